// File: rtl/sm83_clk_pkg.sv
// sm83_clk_pkg
//   Shared types and constants for the SM83 phase-clock generator:
//   controller state encoding, phase counter width, parameter defaults and
//   the per-phase CLK1..CLK9 level table.
package sm83_clk_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_OSC = 3'd0,
    ST_WARMUP   = 3'd1,
    ST_RUN      = 3'd2,
    ST_CLKSTOP  = 3'd3,
    ST_OSCSTOP  = 3'd4
  } clk_state_e;

  localparam int PHASE_W      = 3;
  localparam int NUM_CLKS     = 9;
  localparam int DEF_WARMUP   = 16;
  localparam int DEF_RST_MCYC = 2;

  // Row p gives the CLK levels during phase p; bit n-1 drives CLKn.
  localparam logic [7:0][NUM_CLKS-1:0] PHASE_MASK = {
    9'b101000010,  // 7: CLK2 CLK7 CLK9
    9'b011000010,  // 6: CLK2 CLK7 CLK8
    9'b100100010,  // 5: CLK2 CLK6 CLK9
    9'b010100110,  // 4: CLK2 CLK3 CLK6 CLK8
    9'b100010101,  // 3: CLK1 CLK3 CLK5 CLK9
    9'b010010101,  // 2: CLK1 CLK3 CLK5 CLK8
    9'b100001101,  // 1: CLK1 CLK3 CLK4 CLK9
    9'b010001001   // 0: CLK1 CLK4 CLK8
  };

  function automatic logic [NUM_CLKS-1:0] phase_mask(input logic [PHASE_W-1:0] p);
    return PHASE_MASK[p];
  endfunction

endpackage

// File: rtl/sm83_sync2.sv
// sm83_sync2
//   Two-flop synchronizer for a single asynchronous level.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, clears both flops
//   i_d     : asynchronous input
//   o_q     : synchronized output, two cycles of latency
module sm83_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sm83_clock_gen.sv
// sm83_clock_gen
//   Oscillator warmup, eight-phase M-cycle sequencer and core reset control
//   for the SM83 core. CLK1..CLK9 are registered data levels, not clocks.
//   CLK        : master clock
//   nRESET     : asynchronous active-low reset
//   OSC_STABLE : pad oscillator-stable flag (async)
//   RST_PAD    : external reset request, active-high (async)
//   CLK_ENA    : core request, 0 stops the phase clocks at an M-cycle end
//   OSC_ENA    : core request, 0 enters STOP (oscillator off)
//   WAKE       : wake from STOP (async)
//   CLK1..CLK9 : phase clock levels
//   SYNC_RESET : synchronous core reset, active-high
//   PHASE      : current phase 0..7
//   RUNNING    : high while sequencing phases
module sm83_clock_gen
  import sm83_clk_pkg::*;
#(
  parameter int WARMUP   = DEF_WARMUP,
  parameter int RST_MCYC = DEF_RST_MCYC
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic               OSC_STABLE,
  input  logic               RST_PAD,
  input  logic               CLK_ENA,
  input  logic               OSC_ENA,
  input  logic               WAKE,
  output logic               CLK1,
  output logic               CLK2,
  output logic               CLK3,
  output logic               CLK4,
  output logic               CLK5,
  output logic               CLK6,
  output logic               CLK7,
  output logic               CLK8,
  output logic               CLK9,
  output logic               SYNC_RESET,
  output logic [PHASE_W-1:0] PHASE,
  output logic               RUNNING
);

  localparam int WCW = $clog2(WARMUP + 1);
  localparam int RCW = $clog2(RST_MCYC + 1);

  logic w_osc_s, w_rst_s, w_wake_s;

  sm83_sync2 u_sync_osc  (.i_clk(CLK), .i_rst_n(nRESET), .i_d(OSC_STABLE), .o_q(w_osc_s));
  sm83_sync2 u_sync_rst  (.i_clk(CLK), .i_rst_n(nRESET), .i_d(RST_PAD),    .o_q(w_rst_s));
  sm83_sync2 u_sync_wake (.i_clk(CLK), .i_rst_n(nRESET), .i_d(WAKE),       .o_q(w_wake_s));

  clk_state_e          r_state, w_state_nxt;
  logic [WCW-1:0]      r_wcnt, w_wcnt_nxt;
  logic [PHASE_W-1:0]  r_phase, w_phase_nxt;
  logic [NUM_CLKS-1:0] r_clk, w_clk_nxt;
  logic                r_sync_rst, w_sync_rst_nxt;
  logic [RCW-1:0]      r_rcnt, w_rcnt_nxt;
  logic                r_clean, w_clean_nxt;
  logic                w_ph7, w_warm_done, w_boundary;

  assign w_ph7       = (r_phase == {PHASE_W{1'b1}});
  assign w_warm_done = (r_wcnt == WCW'(WARMUP - 1));
  // A 7 -> 0 wrap that stays in RUN; the only point reset may release.
  assign w_boundary  = (r_state == ST_RUN) && w_ph7 && (w_state_nxt == ST_RUN);

  // State register
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) r_state <= ST_WAIT_OSC;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; stop requests are only honoured at phase 7 so an
  // M-cycle is always emitted whole.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT_OSC: if (w_osc_s) w_state_nxt = ST_WARMUP;
      ST_WARMUP: begin
        if (!w_osc_s)         w_state_nxt = ST_WAIT_OSC;
        else if (w_warm_done) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_ph7) begin
          if (!OSC_ENA)      w_state_nxt = ST_OSCSTOP;
          else if (!CLK_ENA) w_state_nxt = ST_CLKSTOP;
        end
      end
      ST_CLKSTOP: if (CLK_ENA)  w_state_nxt = ST_RUN;
      ST_OSCSTOP: if (w_wake_s) w_state_nxt = ST_WAIT_OSC;
      default:    w_state_nxt = ST_WAIT_OSC;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_wcnt_nxt = '0;
    if (r_state == ST_WARMUP && w_state_nxt == ST_WARMUP) w_wcnt_nxt = r_wcnt + 1'b1;

    // Phase restarts at 0 on every entry into RUN and is parked at 0 outside.
    w_phase_nxt = '0;
    if (r_state == ST_RUN && w_state_nxt == ST_RUN) w_phase_nxt = r_phase + 1'b1;

    // Decode the phase that will be current next cycle, so the registered
    // CLKn line up with PHASE.
    w_clk_nxt = '0;
    if (w_state_nxt == ST_RUN) w_clk_nxt = phase_mask(w_phase_nxt);

    // r_clean: no synced RST_PAD seen so far in the current M-cycle.
    // SYNC_RESET is never set by a state change, so a STOP wake re-warms
    // the oscillator without resetting the core.
    w_sync_rst_nxt = r_sync_rst;
    w_rcnt_nxt     = r_rcnt;
    w_clean_nxt    = r_clean;
    if (r_state == ST_WARMUP) begin
      w_rcnt_nxt  = '0;
      w_clean_nxt = 1'b1;
    end else if (r_state == ST_RUN) begin
      if (w_ph7) begin
        w_clean_nxt = 1'b1;
        if (w_boundary && r_clean && !w_rst_s && r_sync_rst) begin
          if (r_rcnt == RCW'(RST_MCYC - 1)) w_sync_rst_nxt = 1'b0;
          else                              w_rcnt_nxt     = r_rcnt + 1'b1;
        end
      end else if (w_rst_s) begin
        w_clean_nxt = 1'b0;
      end
    end
    if (w_rst_s) begin
      w_sync_rst_nxt = 1'b1;
      w_rcnt_nxt     = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_wcnt     <= '0;
      r_phase    <= '0;
      r_clk      <= '0;
      r_sync_rst <= 1'b1;
      r_rcnt     <= '0;
      r_clean    <= 1'b0;
    end else begin
      r_wcnt     <= w_wcnt_nxt;
      r_phase    <= w_phase_nxt;
      r_clk      <= w_clk_nxt;
      r_sync_rst <= w_sync_rst_nxt;
      r_rcnt     <= w_rcnt_nxt;
      r_clean    <= w_clean_nxt;
    end
  end

  assign {CLK9, CLK8, CLK7, CLK6, CLK5, CLK4, CLK3, CLK2, CLK1} = r_clk;
  assign PHASE      = r_phase;
  assign SYNC_RESET = r_sync_rst;
  assign RUNNING    = (r_state == ST_RUN);

endmodule

// File: tb/tb_sm83_clock_gen.sv
// tb_sm83_clock_gen
//   Directed bench for sm83_clock_gen: power-up warmup, phase decode,
//   reset release timing, clock stop, oscillator stop/wake, warmup abort
//   and asynchronous reset.
module tb_sm83_clock_gen;

  logic       CLK, nRESET, OSC_STABLE, RST_PAD, CLK_ENA, OSC_ENA, WAKE;
  logic       CLK1, CLK2, CLK3, CLK4, CLK5, CLK6, CLK7, CLK8, CLK9;
  logic       SYNC_RESET, RUNNING;
  logic [2:0] PHASE;
  logic [8:0] clks;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ep       = 0;

  assign clks = {CLK9, CLK8, CLK7, CLK6, CLK5, CLK4, CLK3, CLK2, CLK1};

  sm83_clock_gen #(.WARMUP(16), .RST_MCYC(2)) dut (
    .CLK(CLK), .nRESET(nRESET), .OSC_STABLE(OSC_STABLE), .RST_PAD(RST_PAD),
    .CLK_ENA(CLK_ENA), .OSC_ENA(OSC_ENA), .WAKE(WAKE),
    .CLK1(CLK1), .CLK2(CLK2), .CLK3(CLK3), .CLK4(CLK4), .CLK5(CLK5),
    .CLK6(CLK6), .CLK7(CLK7), .CLK8(CLK8), .CLK9(CLK9),
    .SYNC_RESET(SYNC_RESET), .PHASE(PHASE), .RUNNING(RUNNING)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Phase clock levels written straight from the phase ranges.
  function automatic logic [8:0] exp_clk(input int p);
    logic [8:0] e;
    e[0] = (p <= 3);
    e[1] = (p >= 4);
    e[2] = (p >= 1 && p <= 4);
    e[3] = (p <= 1);
    e[4] = (p == 2 || p == 3);
    e[5] = (p == 4 || p == 5);
    e[6] = (p >= 6);
    e[7] = (p % 2 == 0);
    e[8] = (p % 2 == 1);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
  endtask

  task automatic chk_run(input string tag, input logic sr);
    chk({tag, ".running"}, 32'(RUNNING), 32'd1);
    chk({tag, ".phase"},   32'(PHASE),   32'(ep));
    chk({tag, ".clk"},     32'(clks),    32'(exp_clk(ep)));
    chk({tag, ".srst"},    32'(SYNC_RESET), 32'(sr));
  endtask

  task automatic chk_idle(input string tag, input logic sr);
    chk({tag, ".running"}, 32'(RUNNING),    32'd0);
    chk({tag, ".phase"},   32'(PHASE),      32'd0);
    chk({tag, ".clk"},     32'(clks),       32'd0);
    chk({tag, ".srst"},    32'(SYNC_RESET), 32'(sr));
  endtask

  task automatic run_cycles(input string tag, input int n, input logic sr);
    repeat (n) begin
      step(1);
      ep = (ep + 1) % 8;
      chk_run(tag, sr);
    end
  endtask

  initial begin
    nRESET = 1'b0; OSC_STABLE = 1'b0; RST_PAD = 1'b0;
    CLK_ENA = 1'b1; OSC_ENA = 1'b1; WAKE = 1'b0;
    step(3);
    chk_idle("por", 1'b1);

    // Power-up: OSC_STABLE sampled at edge 5, RUN at 5+2+16.
    nRESET = 1'b1; cyc = 0;
    step(4); OSC_STABLE = 1'b1;
    step(18); chk_idle("warmup", 1'b1);
    step(1);  ep = 0; chk_run("run_entry", 1'b1);
    run_cycles("por_hold", 15, 1'b1);
    run_cycles("por_release", 1, 1'b0);

    // RST_PAD pulse at phase 5: asserted 3 cycles later, released after
    // two clean M-cycles.
    run_cycles("pre_pad", 5, 1'b0);
    RST_PAD = 1'b1;
    run_cycles("pad_sync", 1, 1'b0);
    RST_PAD = 1'b0;
    run_cycles("pad_sync", 1, 1'b0);
    run_cycles("pad_assert", 1, 1'b1);
    run_cycles("pad_hold", 15, 1'b1);
    run_cycles("pad_release", 1, 1'b0);

    // CLK_ENA low from phase 3: drain to phase 7, then stop; resume at 0.
    run_cycles("pre_stop", 3, 1'b0);
    CLK_ENA = 1'b0;
    run_cycles("stop_drain", 4, 1'b0);
    step(1); chk_idle("clkstop", 1'b0);
    step(2); chk_idle("clkstop_hold", 1'b0);
    CLK_ENA = 1'b1;
    step(1); ep = 0; chk_run("resume", 1'b0);
    run_cycles("resume", 7, 1'b0);

    // Both enables low at phase 7: OSC stop wins, only WAKE restarts.
    CLK_ENA = 1'b0; OSC_ENA = 1'b0;
    step(1); chk_idle("oscstop", 1'b0);
    CLK_ENA = 1'b1; OSC_ENA = 1'b1;
    step(3); chk_idle("oscstop_hold", 1'b0);
    WAKE = 1'b1;
    step(1); WAKE = 1'b0;
    step(18); chk_idle("rewarm", 1'b0);
    step(1); ep = 0; chk_run("wake_run", 1'b0);
    run_cycles("wake_run", 8, 1'b0);

    // Asynchronous reset mid-RUN, away from any clock edge.
    run_cycles("pre_arst", 3, 1'b0);
    #3 nRESET = 1'b0;
    #1 chk_idle("async_rst", 1'b1);
    OSC_STABLE = 1'b0;
    step(2); chk_idle("async_rst_hold", 1'b1);

    // Warmup aborted at count 10, restarted from 0 after OSC returns.
    nRESET = 1'b1; cyc = 0;
    step(4);  OSC_STABLE = 1'b1;
    step(11); OSC_STABLE = 1'b0;
    step(3);  OSC_STABLE = 1'b1; chk_idle("abort", 1'b1);
    step(5);  chk_idle("no_early_run", 1'b1);
    step(13); chk_idle("rewarm2", 1'b1);
    step(1);  ep = 0; chk_run("run_entry2", 1'b1);
    run_cycles("hold2", 15, 1'b1);
    run_cycles("release2", 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
